dma_sequencer_mc: RTL and testbench

Parametrised multi-channel DMA sequencer. It arbitrates NCH independent requesters onto the single dma_req/dma_ack/dma_end access port of the DMA memory accessor. It tracks up to DEPTH accepted-but-unfinished transfers in an in-order ID queue, so every completion is routed back to the channel that issued it. It generalises the fixed four-channel sequencer with configurable widths, channel count and outstanding depth, a selectable arbitration policy, and protocol-error reporting.

---
 rtl/dma_sequencer_mc.sv | 158 +++++++++++++++
 tb/tb_dma_sequencer_mc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dma_sequencer_mc.sv
// Multi-channel DMA sequencer: arbitrates NCH requesters onto one accessor port and routes completions back through an in-order ID queue.
// Optional macro DMA_SEQ_RR_EN selects round-robin arbitration; fixed priority (lowest index wins) otherwise.
module dma_sequencer_mc #(
  parameter int NCH   = 4,
  parameter int AW    = 21,
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH-1:0]    i_ch_req,
  input  logic [NCH-1:0]    i_ch_rnw,
  input  logic [NCH*AW-1:0] i_ch_addr,
  input  logic [NCH*DW-1:0] i_ch_wd,
  output logic [NCH-1:0]    o_ch_ack,
  output logic [NCH-1:0]    o_ch_done,
  output logic [DW-1:0]     o_ch_rd,
  output logic              o_dma_req,
  output logic              o_dma_rnw,
  output logic [AW-1:0]     o_dma_addr,
  output logic [DW-1:0]     o_dma_wd,
  input  logic              i_dma_ack,
  input  logic              i_dma_end,
  input  logic [DW-1:0]     i_dma_rd,
  output logic              o_busy,
  output logic              o_err
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {ARB, REQ} state_t;

  state_t         r_state;
  logic           r_dma_req;
  logic           r_dma_rnw;
  logic [AW-1:0]  r_dma_addr;
  logic [DW-1:0]  r_dma_wd;
  logic [IW-1:0]  r_grant;
  logic [IW-1:0]  r_q [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_err;

  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic [IW-1:0]  w_winner;
  logic [IW-1:0]  w_head;

  function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
    if (int'(p) == DEPTH - 1) return '0;
    return p + 1'b1;
  endfunction

  assign w_push = r_dma_req & i_dma_ack;
  assign w_pop  = i_dma_end & (r_count != '0);
  assign w_full = (r_count == CW'(DEPTH));
  assign w_head = r_q[r_rptr];

`ifdef DMA_SEQ_RR_EN
  logic [IW-1:0] r_rr_ptr;
  int            w_idx;

  // Search order starts just after the last accepted channel; the lowest offset wins.
  always_comb begin
    w_winner = '0;
    w_idx    = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_idx = (int'(r_rr_ptr) + 1 + k) % NCH;
      if (i_ch_req[w_idx]) w_winner = IW'(w_idx);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rr_ptr <= IW'(NCH - 1);
    else if (w_push) r_rr_ptr <= r_grant;
  end
`else
  always_comb begin
    w_winner = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (i_ch_req[k]) w_winner = IW'(k);
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ARB;
      r_dma_req  <= 1'b0;
      r_dma_rnw  <= 1'b1;
      r_dma_addr <= '0;
      r_dma_wd   <= '0;
      r_grant    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ARB: begin
          if (!w_full && (|i_ch_req)) begin
            r_grant    <= w_winner;
            r_dma_addr <= i_ch_addr[int'(w_winner)*AW +: AW];
            r_dma_wd   <= i_ch_wd[int'(w_winner)*DW +: DW];
            r_dma_rnw  <= i_ch_rnw[w_winner];
            r_dma_req  <= 1'b1;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (i_dma_ack) begin
            r_dma_req <= 1'b0;
            r_state   <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase

      if (w_push) r_wptr <= ptrNext(r_wptr);
      if (w_pop)  r_rptr <= ptrNext(r_rptr);
      // Simultaneous push and pop leaves the occupancy unchanged, even when full.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (i_dma_end && (r_count == '0)) r_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_q[r_wptr] <= r_grant;
  end

  always_comb begin
    o_ch_ack  = '0;
    o_ch_done = '0;
    o_ch_rd   = '0;
    if (w_push) o_ch_ack[r_grant] = 1'b1;
    if (w_pop) begin
      o_ch_done[w_head] = 1'b1;
      o_ch_rd           = i_dma_rd;
    end
  end

  assign o_dma_req  = r_dma_req;
  assign o_dma_rnw  = r_dma_rnw;
  assign o_dma_addr = r_dma_addr;
  assign o_dma_wd   = r_dma_wd;
  assign o_busy     = r_dma_req | (r_count != '0);
  assign o_err      = r_err;

endmodule

// File: tb/tb_dma_sequencer_mc.sv
// Directed bench for dma_sequencer_mc: cycle-vector table plus an arbitration-order sequence.
module tb_dma_sequencer_mc;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [3:0]  i_ch_req = '0;
  logic [3:0]  i_ch_rnw = 4'b0011;
  logic [83:0] i_ch_addr = {21'h0ABCD, 21'h08001, 21'h08000, 21'h10000};
  logic [31:0] i_ch_wd = {8'h44, 8'h5A, 8'h22, 8'h11};
  logic [3:0]  o_ch_ack;
  logic [3:0]  o_ch_done;
  logic [7:0]  o_ch_rd;
  logic        o_dma_req;
  logic        o_dma_rnw;
  logic [20:0] o_dma_addr;
  logic [7:0]  o_dma_wd;
  logic        i_dma_ack = 1'b0;
  logic        i_dma_end = 1'b0;
  logic [7:0]  i_dma_rd = '0;
  logic        o_busy;
  logic        o_err;

  int errCount = 0;
  int checkCount = 0;

  dma_sequencer_mc #(.NCH(4), .AW(21), .DW(8), .DEPTH(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ch_req(i_ch_req), .i_ch_rnw(i_ch_rnw), .i_ch_addr(i_ch_addr), .i_ch_wd(i_ch_wd),
    .o_ch_ack(o_ch_ack), .o_ch_done(o_ch_done), .o_ch_rd(o_ch_rd),
    .o_dma_req(o_dma_req), .o_dma_rnw(o_dma_rnw), .o_dma_addr(o_dma_addr), .o_dma_wd(o_dma_wd),
    .i_dma_ack(i_dma_ack), .i_dma_end(i_dma_end), .i_dma_rd(i_dma_rd),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        ack;
    logic        dend;
    logic [7:0]  rd;
    logic        expReq;
    logic [20:0] expAddr;
    logic        expRnw;
    logic [7:0]  expWd;
    logic [3:0]  expAck;
    logic [3:0]  expDone;
    logic [7:0]  expRd;
    logic        expBusy;
    logic        expErr;
  } vec_t;

  vec_t vecs[38];

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic ack,
                              input logic dend, input logic [7:0] rd, input logic eReq,
                              input logic [20:0] eAddr, input logic eRnw, input logic [7:0] eWd,
                              input logic [3:0] eAck, input logic [3:0] eDone, input logic [7:0] eRd,
                              input logic eBusy, input logic eErr);
    vec_t v;
    v.rst = rst; v.req = req; v.ack = ack; v.dend = dend; v.rd = rd;
    v.expReq = eReq; v.expAddr = eAddr; v.expRnw = eRnw; v.expWd = eWd;
    v.expAck = eAck; v.expDone = eDone; v.expRd = eRd; v.expBusy = eBusy; v.expErr = eErr;
    return v;
  endfunction

  function automatic int onehotIdx(input logic [3:0] v);
    int idx = -1;
    int ones = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        idx = i;
        ones++;
      end
    end
    return (ones == 1) ? idx : -1;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge i_clk);
    i_rst     = v.rst;
    i_ch_req  = v.req;
    i_dma_ack = v.ack;
    i_dma_end = v.dend;
    i_dma_rd  = v.rd;
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int n);
    checkField($sformatf("v%0d dmaReq", n), 32'(o_dma_req), 32'(v.expReq));
    checkField($sformatf("v%0d dmaAddr", n), 32'(o_dma_addr), 32'(v.expAddr));
    checkField($sformatf("v%0d dmaRnw", n), 32'(o_dma_rnw), 32'(v.expRnw));
    checkField($sformatf("v%0d dmaWd", n), 32'(o_dma_wd), 32'(v.expWd));
    checkField($sformatf("v%0d chAck", n), 32'(o_ch_ack), 32'(v.expAck));
    checkField($sformatf("v%0d chDone", n), 32'(o_ch_done), 32'(v.expDone));
    if (v.expDone != 4'b0000)
      checkField($sformatf("v%0d chRd", n), 32'(o_ch_rd), 32'(v.expRd));
    checkField($sformatf("v%0d busy", n), 32'(o_busy), 32'(v.expBusy));
    checkField($sformatf("v%0d err", n), 32'(o_err), 32'(v.expErr));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [20:0] chAddr [4];
    int pend[$];
    int nGrant;
    int gIdx;
    int dIdx;
    int expG;
    chAddr[0] = 21'h10000; chAddr[1] = 21'h08000; chAddr[2] = 21'h08001; chAddr[3] = 21'h0ABCD;

    // rst req ack end rd | dmaReq addr rnw wd ack done rd busy err
    vecs[0]  = mk(0, 4'b0000, 0, 0, 8'h00, 0, 21'h00000, 1, 8'h00, 4'b0000, 4'b0000, 8'h00, 0, 0);
    vecs[1]  = mk(0, 4'b0110, 0, 0, 8'h00, 0, 21'h00000, 1, 8'h00, 4'b0000, 4'b0000, 8'h00, 0, 0);
    vecs[2]  = mk(0, 4'b0110, 0, 0, 8'h00, 1, 21'h08000, 1, 8'h22, 4'b0000, 4'b0000, 8'h00, 1, 0);
    vecs[3]  = mk(0, 4'b0110, 1, 0, 8'h00, 1, 21'h08000, 1, 8'h22, 4'b0010, 4'b0000, 8'h00, 1, 0);
    vecs[4]  = mk(0, 4'b0100, 0, 0, 8'h00, 0, 21'h08000, 1, 8'h22, 4'b0000, 4'b0000, 8'h00, 1, 0);
    vecs[5]  = mk(0, 4'b0100, 0, 0, 8'h00, 1, 21'h08001, 0, 8'h5A, 4'b0000, 4'b0000, 8'h00, 1, 0);
    vecs[6]  = mk(0, 4'b0100, 1, 0, 8'h00, 1, 21'h08001, 0, 8'h5A, 4'b0100, 4'b0000, 8'h00, 1, 0);
    vecs[7]  = mk(0, 4'b0000, 0, 1, 8'hC3, 0, 21'h08001, 0, 8'h5A, 4'b0000, 4'b0010, 8'hC3, 1, 0);
    vecs[8]  = mk(0, 4'b0000, 0, 1, 8'h7E, 0, 21'h08001, 0, 8'h5A, 4'b0000, 4'b0100, 8'h7E, 1, 0);
    vecs[9]  = mk(0, 4'b0000, 0, 0, 8'h00, 0, 21'h08001, 0, 8'h5A, 4'b0000, 4'b0000, 8'h00, 0, 0);
    vecs[10] = mk(0, 4'b0001, 0, 0, 8'h00, 0, 21'h08001, 0, 8'h5A, 4'b0000, 4'b0000, 8'h00, 0, 0);
    vecs[11] = mk(0, 4'b0001, 1, 0, 8'h00, 1, 21'h10000, 1, 8'h11, 4'b0001, 4'b0000, 8'h00, 1, 0);
    vecs[12] = mk(0, 4'b0001, 0, 0, 8'h00, 0, 21'h10000, 1, 8'h11, 4'b0000, 4'b0000, 8'h00, 1, 0);
    vecs[13] = mk(0, 4'b0001, 1, 0, 8'h00, 1, 21'h10000, 1, 8'h11, 4'b0001, 4'b0000, 8'h00, 1, 0);
    vecs[14] = mk(0, 4'b0001, 0, 0, 8'h00, 0, 21'h10000, 1, 8'h11, 4'b0000, 4'b0000, 8'h00, 1, 0);
    vecs[15] = mk(0, 4'b0001, 0, 0, 8'h00, 0, 21'h10000, 1, 8'h11, 4'b0000, 4'b0000, 8'h00, 1, 0);
    vecs[16] = mk(0, 4'b0001, 0, 1, 8'h99, 0, 21'h10000, 1, 8'h11, 4'b0000, 4'b0001, 8'h99, 1, 0);
    vecs[17] = mk(0, 4'b0001, 0, 0, 8'h00, 0, 21'h10000, 1, 8'h11, 4'b0000, 4'b0000, 8'h00, 1, 0);
    vecs[18] = mk(0, 4'b0001, 1, 0, 8'h00, 1, 21'h10000, 1, 8'h11, 4'b0001, 4'b0000, 8'h00, 1, 0);
    vecs[19] = mk(0, 4'b1000, 0, 0, 8'h00, 0, 21'h10000, 1, 8'h11, 4'b0000, 4'b0000, 8'h00, 1, 0);
    vecs[20] = mk(0, 4'b1000, 0, 1, 8'h5C, 0, 21'h10000, 1, 8'h11, 4'b0000, 4'b0001, 8'h5C, 1, 0);
    vecs[21] = mk(0, 4'b1000, 0, 0, 8'h00, 0, 21'h10000, 1, 8'h11, 4'b0000, 4'b0000, 8'h00, 1, 0);
    vecs[22] = mk(0, 4'b1000, 1, 1, 8'hA5, 1, 21'h0ABCD, 0, 8'h44, 4'b1000, 4'b0001, 8'hA5, 1, 0);
    vecs[23] = mk(0, 4'b0000, 0, 0, 8'h00, 0, 21'h0ABCD, 0, 8'h44, 4'b0000, 4'b0000, 8'h00, 1, 0);
    vecs[24] = mk(0, 4'b0000, 0, 1, 8'h3C, 0, 21'h0ABCD, 0, 8'h44, 4'b0000, 4'b1000, 8'h3C, 1, 0);
    vecs[25] = mk(0, 4'b0000, 0, 0, 8'h00, 0, 21'h0ABCD, 0, 8'h44, 4'b0000, 4'b0000, 8'h00, 0, 0);
    vecs[26] = mk(0, 4'b0000, 0, 1, 8'hFF, 0, 21'h0ABCD, 0, 8'h44, 4'b0000, 4'b0000, 8'h00, 0, 0);
    vecs[27] = mk(0, 4'b0000, 0, 0, 8'h00, 0, 21'h0ABCD, 0, 8'h44, 4'b0000, 4'b0000, 8'h00, 0, 1);
    vecs[28] = mk(0, 4'b0000, 0, 0, 8'h00, 0, 21'h0ABCD, 0, 8'h44, 4'b0000, 4'b0000, 8'h00, 0, 1);
    vecs[29] = mk(1, 4'b0000, 0, 0, 8'h00, 0, 21'h0ABCD, 0, 8'h44, 4'b0000, 4'b0000, 8'h00, 0, 1);
    vecs[30] = mk(0, 4'b0000, 0, 0, 8'h00, 0, 21'h00000, 1, 8'h00, 4'b0000, 4'b0000, 8'h00, 0, 0);
    vecs[31] = mk(0, 4'b0010, 0, 0, 8'h00, 0, 21'h00000, 1, 8'h00, 4'b0000, 4'b0000, 8'h00, 0, 0);
    vecs[32] = mk(0, 4'b0010, 1, 0, 8'h00, 1, 21'h08000, 1, 8'h22, 4'b0010, 4'b0000, 8'h00, 1, 0);
    vecs[33] = mk(0, 4'b0010, 0, 0, 8'h00, 0, 21'h08000, 1, 8'h22, 4'b0000, 4'b0000, 8'h00, 1, 0);
    vecs[34] = mk(1, 4'b0010, 0, 0, 8'h00, 1, 21'h08000, 1, 8'h22, 4'b0000, 4'b0000, 8'h00, 1, 0);
    vecs[35] = mk(0, 4'b0000, 0, 0, 8'h00, 0, 21'h00000, 1, 8'h00, 4'b0000, 4'b0000, 8'h00, 0, 0);
    vecs[36] = mk(0, 4'b0000, 0, 1, 8'h12, 0, 21'h00000, 1, 8'h00, 4'b0000, 4'b0000, 8'h00, 0, 0);
    vecs[37] = mk(0, 4'b0000, 0, 0, 8'h00, 0, 21'h00000, 1, 8'h00, 4'b0000, 4'b0000, 8'h00, 0, 1);

    repeat (2) @(negedge i_clk);

    for (int n = 0; n < 38; n++) begin
      applyStimulus(vecs[n]);
      checkOutput(vecs[n], n);
    end

    // Arbitration order with all channels held: the accessor acks at once and retires one entry per cycle.
    @(negedge i_clk);
    i_rst = 1'b1; i_ch_req = '0; i_dma_ack = 1'b0; i_dma_end = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    nGrant = 0;
    for (int cyc = 0; cyc < 100 && nGrant < 8; cyc++) begin
      @(negedge i_clk);
      i_ch_req  = 4'hF;
      i_dma_ack = o_dma_req;
      i_dma_end = (pend.size() > 0);
      i_dma_rd  = 8'(cyc + 8'h40);
      #1;
      if (i_dma_end) begin
        dIdx = onehotIdx(o_ch_done);
        checkField($sformatf("rr done%0d", cyc), 32'(dIdx), 32'(pend.pop_front()));
        checkField($sformatf("rr rd%0d", cyc), 32'(o_ch_rd), 32'(i_dma_rd));
      end
      if (i_dma_ack) begin
        gIdx = onehotIdx(o_ch_ack);
`ifdef DMA_SEQ_RR_EN
        expG = nGrant % 4;
`else
        expG = 0;
`endif
        checkField($sformatf("rr grant%0d", nGrant), 32'(gIdx), 32'(expG));
        checkField($sformatf("rr addr%0d", nGrant), 32'(o_dma_addr), 32'(chAddr[expG]));
        pend.push_back(gIdx);
        nGrant++;
      end
    end
    checkField("rr grant count", 32'(nGrant), 32'd8);

    for (int cyc = 0; cyc < 10 && pend.size() > 0; cyc++) begin
      @(negedge i_clk);
      i_ch_req  = '0;
      i_dma_ack = 1'b0;
      i_dma_end = 1'b1;
      i_dma_rd  = 8'(cyc + 8'h80);
      #1;
      dIdx = onehotIdx(o_ch_done);
      checkField($sformatf("rr drain%0d", cyc), 32'(dIdx), 32'(pend.pop_front()));
    end
    @(negedge i_clk);
    i_ch_req = '0; i_dma_ack = 1'b0; i_dma_end = 1'b0;
    #1;
    checkField("rr drained", 32'(pend.size()), 32'd0);
    checkField("rr idle busy", 32'(o_busy), 32'd0);
    checkField("rr err clean", 32'(o_err), 32'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
